// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES-128 key schedule sequencer with an 11x128 round-key file
// Drives an external single-round transform ten times and serves RK0..RK10 through a read port.
module aes_key_sched_ctrl #(
  parameter int TIMEOUT_CYC = 64,
  parameter bit RD_REG      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  input  logic         abort_i,
  output logic         tf_start_o,
  output logic [127:0] tf_key_o,
  output logic [3:0]   tf_round_o,
  input  logic         tf_done_i,
  input  logic [127:0] tf_key_i,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_data_o,
  output logic         busy_o,
  output logic         keys_valid_o,
  output logic         done_o,
  output logic         error_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  state_t          state;
  state_t          state_nxt;
  logic [127:0]    rf [11];
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  logic [3:0]      rk_wr_idx;

  logic accept;
  logic rk_we;
  logic round_inc;
  logic wd_clr;
  logic wd_inc;
  logic kv_set;

  assign rk_wr_idx  = tf_round_o + 4'd1;
  // The counter value seen in the last allowed WAIT cycle is TIMEOUT_CYC-1.
  assign wd_expired = (TIMEOUT_CYC != 0) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    key_ready_o = 1'b0;
    tf_start_o  = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;
    accept      = 1'b0;
    rk_we       = 1'b0;
    round_inc   = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    kv_set      = 1'b0;
    case (state)
      S_IDLE: begin
        key_ready_o = 1'b1;
        if (key_valid_i) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tf_start_o = 1'b1;
        busy_o     = 1'b1;
        wd_clr     = 1'b1;
        state_nxt  = abort_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        busy_o = 1'b1;
        wd_inc = 1'b1;
        // Abort outranks a coincident result so a cancelled round never lands in the file.
        if (abort_i) begin
          state_nxt = S_IDLE;
        end else if (tf_done_i) begin
          rk_we = 1'b1;
          if (tf_round_o == 4'd9) begin
            state_nxt = S_DONE;
          end else begin
            round_inc = 1'b1;
            state_nxt = S_START;
          end
        end else if (wd_expired) begin
          error_o   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        done_o    = 1'b1;
        kv_set    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tf_key_o     <= '0;
      tf_round_o   <= '0;
      keys_valid_o <= 1'b0;
      wd_cnt       <= '0;
      for (int i = 0; i < 11; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (accept) begin
        rf[0]        <= key_i;
        tf_key_o     <= key_i;
        tf_round_o   <= '0;
        keys_valid_o <= 1'b0;
      end
      if (rk_we) begin
        rf[rk_wr_idx] <= tf_key_i;
        tf_key_o      <= tf_key_i;
      end
      if (round_inc) begin
        tf_round_o <= tf_round_o + 4'd1;
      end
      if (kv_set) begin
        keys_valid_o <= 1'b1;
      end
      if (wd_clr) begin
        wd_cnt <= '0;
      end else if (wd_inc && (TIMEOUT_CYC != 0)) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

  logic [127:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < 11; i++) begin
      if (rd_idx_i == 4'(i)) begin
        rd_sel = rf[i];
      end
    end
  end

  generate
    if (RD_REG) begin : g_rd_reg
      logic [127:0] rd_q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else begin
          rd_q <= rd_sel;
        end
      end
      assign rd_data_o = rd_q;
    end else begin : g_rd_comb
      assign rd_data_o = rd_sel;
    end
  endgenerate

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - scoreboard bench for aes_key_sched_ctrl with a behavioural round_key_tf stub
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] KEY_F  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_F  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_F = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid_i;
  logic [127:0] key_i;
  logic         key_ready_o;
  logic         abort_i;
  logic         tf_start_o;
  logic [127:0] tf_key_o;
  logic [3:0]   tf_round_o;
  logic         tf_done_i;
  logic [127:0] tf_key_i;
  logic [3:0]   rd_idx_i;
  logic [127:0] rd_data_o;
  logic         busy_o;
  logic         keys_valid_o;
  logic         done_o;
  logic         error_o;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.TIMEOUT_CYC(64), .RD_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid_i(key_valid_i), .key_i(key_i),
    .key_ready_o(key_ready_o), .abort_i(abort_i), .tf_start_o(tf_start_o),
    .tf_key_o(tf_key_o), .tf_round_o(tf_round_o), .tf_done_i(tf_done_i),
    .tf_key_i(tf_key_i), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .keys_valid_o(keys_valid_o), .done_o(done_o), .error_o(error_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference AES-128 key expansion used by the transform stub.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd0: return 8'h01;  4'd1: return 8'h02;  4'd2: return 8'h04;  4'd3: return 8'h08;
      4'd4: return 8'h10;  4'd5: return 8'h20;  4'd6: return 8'h40;  4'd7: return 8'h80;
      4'd8: return 8'h1b;  4'd9: return 8'h36;  default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_rk(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w3  = k[31:0];
    logic [31:0] rot = {w3[23:0], w3[31:24]};
    logic [31:0] t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
                       ^ {rcon(r), 24'h000000};
    logic [31:0] n0  = k[127:96] ^ t;
    logic [31:0] n1  = k[95:64] ^ n0;
    logic [31:0] n2  = k[63:32] ^ n1;
    logic [31:0] n3  = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] mf [11];
  logic [127:0] m2 [11];

  // Transform stub: answers each start pulse after stub_lat WAIT cycles.
  int           stub_lat    = 1;
  bit           stub_en     = 1'b1;
  int           abort_round = 15;
  bit           pending     = 1'b0;
  int           wait_cnt    = 0;
  logic [127:0] cap_key     = '0;
  logic [3:0]   cap_round   = '0;

  initial begin
    tf_done_i = 1'b0;
    tf_key_i  = '0;
    abort_i   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tf_done_i = 1'b0;
      abort_i   = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (wait_cnt == 0) begin
            tf_done_i = 1'b1;
            tf_key_i  = next_rk(cap_key, cap_round);
            if (int'(cap_round) == abort_round) abort_i = 1'b1;
            pending = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
        if (tf_start_o) begin
          pending   = stub_en;
          wait_cnt  = stub_lat - 1;
          cap_key   = tf_key_o;
          cap_round = tf_round_o;
        end
      end
    end
  end

  // Monitor: pops expected events / read data whenever the DUT presents them.
  int           ev_q [$];
  logic [127:0] rd_q [$];
  logic [3:0]   round_log [$];
  bit           rd_req = 1'b0;
  bit           rd_pend = 1'b0;
  int           starts = 0;
  int           accepts = 0;
  int           stab_err = 0;
  int           ready_err = 0;
  logic [127:0] hold_key = '0;
  logic [3:0]   hold_round = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done_o) begin
          if (ev_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL event_unexpected actual=done required=none");
          end else begin
            check("event_kind_done", 128'(EV_DONE), 128'(ev_q.pop_front()));
          end
        end
        if (error_o) begin
          if (ev_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL event_unexpected actual=error required=none");
          end else begin
            check("event_kind_error", 128'(EV_ERR), 128'(ev_q.pop_front()));
          end
        end
        if (tf_start_o) begin
          starts++;
          round_log.push_back(tf_round_o);
          hold_key   = tf_key_o;
          hold_round = tf_round_o;
        end else if (busy_o) begin
          if (tf_key_o !== hold_key || tf_round_o !== hold_round) stab_err++;
        end
        if (key_valid_i && key_ready_o) accepts++;
        if (key_ready_o == (busy_o || done_o)) ready_err++;
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected actual=%h required=none", rd_data_o);
        end else begin
          check("rd_data", rd_data_o, rd_q.pop_front());
        end
      end
      rd_pend = rd_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic rd(input int idx, input logic [127:0] exp);
    rd_idx_i = 4'(idx);
    rd_q.push_back(exp);
    rd_req = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic rd_end();
    rd_req = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
  endtask

  task automatic accept_key(input logic [127:0] k);
    key_i = k;
    key_valid_i = 1'b1;
    for (int c = 0; c < 20 && key_ready_o; c++) begin @(posedge clk); #2; end
    check("accept_ready_low", 128'(key_ready_o), 128'(0));
  endtask

  // Returns edges from the accept edge until done_o or error_o is seen.
  task automatic run_key(input logic [127:0] k, input bit hold, output int n);
    bit seen = 1'b0;
    accept_key(k);
    if (!hold) key_valid_i = 1'b0;
    n = 0;
    for (int c = 0; c < 2000; c++) begin
      if (done_o || error_o) begin seen = 1'b1; break; end
      @(posedge clk); #2;
      n++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL run_timeout actual=no_done required=done_or_error");
    end
    key_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"},  128'(key_ready_o),  128'(1));
    check({tag, "_tf_start"},   128'(tf_start_o),   128'(0));
    check({tag, "_busy"},       128'(busy_o),       128'(0));
    check({tag, "_keys_valid"}, 128'(keys_valid_o), 128'(0));
    check({tag, "_done"},       128'(done_o),       128'(0));
    check({tag, "_error"},      128'(error_o),      128'(0));
    check({tag, "_tf_key"},     tf_key_o,           128'(0));
    check({tag, "_tf_round"},   128'(tf_round_o),   128'(0));
    check({tag, "_rd_data"},    rd_data_o,          128'(0));
  endtask

  initial begin
    int n;
    int s0;
    int a0;
    bit found;
    rst_n = 1'b0;
    key_valid_i = 1'b0;
    key_i = '0;
    rd_idx_i = '0;
    mf[0] = KEY_F;
    m2[0] = KEY_2;
    for (int r = 0; r < 10; r++) begin
      mf[r+1] = next_rk(mf[r], 4'(r));
      m2[r+1] = next_rk(m2[r], 4'(r));
    end

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #2;

    // FIPS-197 key, one-cycle transform, key_valid_i held through expansion.
    s0 = starts; a0 = accepts; round_log.delete();
    ev_q.push_back(EV_DONE);
    run_key(KEY_F, 1'b1, n);
    check("fips_latency", 128'(n), 128'(20));
    check("fips_starts", 128'(starts - s0), 128'(10));
    check("fips_accepts", 128'(accepts - a0), 128'(1));
    check("fips_round_count", 128'(round_log.size()), 128'(10));
    for (int i = 0; i < 10 && i < round_log.size(); i++) begin
      check("fips_round_seq", 128'(round_log[i]), 128'(i));
    end
    @(posedge clk); #2;
    check("fips_keys_valid", 128'(keys_valid_o), 128'(1));
    check("fips_ready_again", 128'(key_ready_o), 128'(1));
    for (int i = 0; i < 16; i++) begin
      if (i == 1) rd(i, RK1_F);
      else if (i == 10) rd(i, RK10_F);
      else if (i <= 10) rd(i, mf[i]);
      else rd(i, 128'(0));
    end
    rd_end();

    // Second key with a three-cycle transform.
    stub_lat = 3;
    s0 = starts;
    ev_q.push_back(EV_DONE);
    run_key(KEY_2, 1'b0, n);
    check("k2_latency", 128'(n), 128'(40));
    check("k2_starts", 128'(starts - s0), 128'(10));
    stub_lat = 1;
    @(posedge clk); #2;
    rd(10, RK10_2);
    rd(5, m2[5]);
    rd_end();

    // Abort coincident with the round-4 result.
    abort_round = 4;
    s0 = starts;
    accept_key(KEY_F);
    key_valid_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (abort_i) begin found = 1'b1; break; end
      @(posedge clk); #2;
    end
    check("abort_seen", 128'(found), 128'(1));
    check("abort_round", 128'(tf_round_o), 128'(4));
    @(posedge clk); #2;
    abort_round = 15;
    check("abort_idle", 128'(key_ready_o), 128'(1));
    check("abort_busy", 128'(busy_o), 128'(0));
    check("abort_keys_valid", 128'(keys_valid_o), 128'(0));
    check("abort_starts", 128'(starts - s0), 128'(5));
    repeat (5) begin @(posedge clk); #2; end
    rd(5, m2[5]);
    rd(4, mf[4]);
    rd_end();

    // Watchdog: the stub never answers.
    stub_en = 1'b0;
    ev_q.push_back(EV_ERR);
    run_key(KEY_2, 1'b0, n);
    check("timeout_latency", 128'(n), 128'(64));
    check("timeout_error", 128'(error_o), 128'(1));
    check("timeout_no_done", 128'(done_o), 128'(0));
    @(posedge clk); #2;
    stub_en = 1'b1;
    check("timeout_idle", 128'(key_ready_o), 128'(1));
    check("timeout_keys_valid", 128'(keys_valid_o), 128'(0));
    check("timeout_busy", 128'(busy_o), 128'(0));

    // Reset in the middle of an expansion.
    accept_key(KEY_F);
    key_valid_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (tf_round_o == 4'd3) begin found = 1'b1; break; end
      @(posedge clk); #2;
    end
    check("midreset_reached", 128'(found), 128'(1));
    rst_n = 1'b0;
    @(posedge clk); #2;
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    rd(0, 128'(0));
    rd(1, 128'(0));
    rd_end();

    repeat (5) begin @(posedge clk); #2; end
    check("events_drained", 128'(ev_q.size()), 128'(0));
    check("reads_drained", 128'(rd_q.size()), 128'(0));
    check("wait_stability", 128'(stab_err), 128'(0));
    check("ready_protocol", 128'(ready_err), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
